// File: rtl/brick_spawner.sv
// Brick spawner: picks when and where a new brick appears, which slot receives it,
// and ramps the shared fall-speed threshold as spawns accumulate.
module brick_spawner #(
    parameter int unsigned NUM_SLOTS        = 4,
    parameter logic [24:0] SPAWN_PERIOD     = 25'd25_000_000,
    parameter logic [7:0]  X_MAX            = 8'd198,
    parameter logic [7:0]  INIT_Y           = 8'd0,
    parameter logic [7:0]  LFSR_SEED        = 8'hA5,
    parameter logic [24:0] DELAY_START      = 25'd2_000_000,
    parameter logic [24:0] DELAY_STEP       = 25'd100_000,
    parameter logic [24:0] DELAY_MIN        = 25'd200_000,
    parameter logic [3:0]  SPAWNS_PER_LEVEL = 4'd8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_SLOTS-1:0] exist,
    input  logic                 game_over,
    output logic [NUM_SLOTS-1:0] created,
    output logic [7:0]           init_x,
    output logic [7:0]           init_y,
    output logic [24:0]          delay_done,
    output logic [3:0]           level,
    output logic                 running
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [25:0] DELAY_FLOOR = {1'b0, DELAY_MIN} + {1'b0, DELAY_STEP};

    state_t                state, state_next;
    logic [24:0]           timer;
    logic                  pending;
    logic [3:0]            spawn_count;
    logic [1:0]            hold [NUM_SLOTS];
    logic [7:0]            lfsr;
    logic [7:0]            xm;
    logic [24:0]           delay_dec;
    logic [NUM_SLOTS-1:0]  free;
    logic [NUM_SLOTS-1:0]  pick;
    logic                  any_free;
    logic                  wrap;
    logic                  spawn;

    assign init_y    = INIT_Y;
    assign xm        = (lfsr > X_MAX) ? lfsr - X_MAX - 8'd1 : lfsr;
    assign delay_dec = ({1'b0, delay_done} < DELAY_FLOOR) ? DELAY_MIN : delay_done - DELAY_STEP;

    // hold covers the gap before a freshly spawned brick reports exist
    always_comb begin
        free = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            free[i] = ~exist[i] & (hold[i] == 2'd0);
        end
    end

    always_comb begin
        pick     = '0;
        any_free = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (free[i] && !any_free) begin
                pick[i]  = 1'b1;
                any_free = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        running    = 1'b0;
        wrap       = 1'b0;
        spawn      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                running = 1'b1;
                if (game_over) begin
                    state_next = HALT;
                end else begin
                    wrap  = (timer == SPAWN_PERIOD - 25'd1);
                    spawn = pending & any_free;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            created     <= '0;
            init_x      <= '0;
            delay_done  <= DELAY_START;
            level       <= '0;
            timer       <= '0;
            pending     <= 1'b0;
            spawn_count <= '0;
            lfsr        <= LFSR_SEED;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                hold[i] <= '0;
            end
        end else begin
            lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            created <= spawn ? pick : '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (spawn && pick[i]) begin
                    hold[i] <= 2'd3;
                end else if (hold[i] != 2'd0) begin
                    hold[i] <= hold[i] - 2'd1;
                end
            end

            if (state == IDLE && start) begin
                pending <= 1'b1;
                timer   <= '0;
            end else if (state == RUN && !game_over) begin
                timer <= wrap ? '0 : timer + 25'd1;
                // a wrap on the spawn edge is a fresh request and survives the spawn
                if (wrap) begin
                    pending <= 1'b1;
                end else if (spawn) begin
                    pending <= 1'b0;
                end
            end

            if (spawn) begin
                init_x <= xm;
                if (spawn_count + 4'd1 == SPAWNS_PER_LEVEL) begin
                    spawn_count <= '0;
                    delay_done  <= delay_dec;
                    if (level != 4'd15) level <= level + 4'd1;
                end else begin
                    spawn_count <= spawn_count + 4'd1;
                end
            end
        end
    end

endmodule

// File: doc/brick_spawner.md
Name: brick_spawner

Overview:
- Upstream of the per-slot brick instances; decides when a new brick appears, in which slot, at which x position, and how fast the bricks fall.
- Drives each slot's created pulse, the shared init_x/init_y spawn position and the shared delay_done fall-speed threshold.
- Consumes each slot's exist flag and the ORed game_over; difficulty ramps as spawns accumulate.

Parameters:
NUM_SLOTS, 4, number of brick instances served (1..8)
SPAWN_PERIOD, 25'd25_000_000, clk cycles between spawn requests (>=2)
X_MAX, 8'd198, largest legal init_x (screen width minus brick width)
INIT_Y, 8'd0, y given to every new brick
LFSR_SEED, 8'hA5, LFSR value after reset (non-zero)
DELAY_START, 25'd2_000_000, delay_done after reset
DELAY_STEP, 25'd100_000, delay_done decrement per level
DELAY_MIN, 25'd200_000, delay_done floor
SPAWNS_PER_LEVEL, 4'd8, spawns per level-up (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
start  input  1  level-sensitive; leaves IDLE when high
exist  input  NUM_SLOTS  exist flag from each brick slot
game_over  input  1  OR of all slots' game_over
created  output  NUM_SLOTS  one-hot, one-cycle spawn pulse
init_x  output  8  spawn x; valid in the created cycle and held until next spawn
init_y  output  8  constant INIT_Y
delay_done  output  25  fall-speed threshold for all slots
level  output  4  current difficulty level, saturates at 15
running  output  1  high in RUN

Behaviour:
- Reset (rst low at a clk edge, any state, mid-operation included), effective that edge:
  - state=IDLE, created=0, init_x=0, init_y=INIT_Y, delay_done=DELAY_START, level=0, running=0.
  - timer=0, pending=0, spawn_count=0, hold[*]=0, lfsr=LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4.
  - Each non-reset cycle: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances in every state; never reaches 0.
- Position map: xm = (lfsr > X_MAX) ? lfsr - X_MAX - 1 : lfsr, using the pre-advance lfsr of that cycle. Result always in 0..X_MAX.
- States:
  - IDLE: running=0, created=0. When start=1: -> RUN, set pending=1 so the first spawn is immediate, timer=0.
  - RUN: running=1.
    - timer counts 0..SPAWN_PERIOD-1 then wraps to 0; the wrap sets pending=1.
    - pending is a single bit; repeated wraps while pending do not accumulate.
  - HALT: entered from RUN when game_over=1. created=0, timer frozen, running=0. Exit only by reset.
- Slot availability: free[i] = ~exist[i] & (hold[i]==0).
  - hold[i] is a 2-bit down-counter, loaded with 3 when slot i is spawned and decremented to 0.
  - It covers the two-cycle gap before a brick's exist is valid.
- Spawn condition: in RUN with pending=1, game_over=0 and at least one free slot. Next edge:
  - created = one-hot of the lowest-index free slot; all other bits 0.
  - init_x <= xm; pending <= 0; hold[slot] <= 3.
  - created drops to 0 the following cycle.
- No free slot: pending stays 1; the spawn fires in the first cycle a slot becomes free. The timer keeps running.
- Simultaneous game_over and spawn condition: game_over wins. No created pulse; -> HALT.
- Difficulty, updated on the spawn edge:
  - spawn_count increments. When it reaches SPAWNS_PER_LEVEL it resets to 0 and level increments, saturating at 15.
  - On a level increment, delay_done <= max(delay_done - DELAY_STEP, DELAY_MIN). The subtraction must not underflow: if delay_done < DELAY_MIN + DELAY_STEP, the result is DELAY_MIN.
- Only delay_done, level and init_x change outside reset; init_y is constant.

Test Plan:
- Use SPAWN_PERIOD=10 and SPAWNS_PER_LEVEL=2 for benches; exist is modelled by the bench.
- Reset then start=1 with all exist=0 -> created=4'b0001 exactly one cycle later for one cycle; init_x equals model xm; running=1; next spawn on slot 1 ten cycles later (slot 0 held by model exist=1).
- All four exist=1 across three timer wraps, then exist[2] falls -> exactly one created=4'b0100 pulse on the first cycle slot 2 is free, not three.
- Run 10,000 cycles, releasing each slot's exist 20 cycles after its spawn -> init_x always <= 198; never two bits set in created; same slot never re-spawned within 3 cycles.
- DELAY_START=500, DELAY_STEP=200, DELAY_MIN=200 -> delay_done 500, then 300 after 2 spawns, 200 after 4, stays 200; level 1, 2, 3; level saturates at 15.
- game_over=1 in the same cycle as a pending spawn -> created stays 0, running=0, state HALT; start toggled has no effect; rst low for one edge -> IDLE with all reset values and lfsr=8'hA5.
